ex_mem: RTL and testbench

Pipeline register between the execute (EX) and memory-access (MEM) stages of the five-stage MIPS core. Captures EX results on each rising clock edge and presents them to MEM one cycle later. Honors the global stall vector and the exception flush. Also holds the intermediate HI/LO product and cycle count for two-cycle `madd`/`msub` instructions, returning them to EX while EX is stalled.

---
 rtl/ex_mem.sv | 99 +++++++++
 tb/tb_ex_mem.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// ============================================================================
// Module   : ex_mem
// Brief    : EX/MEM pipeline register with stall/flush handling and the
//            madd/msub HI/LO feedback latch (built only with EX_MEM_MADD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,

    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,

    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [7:0]  mem_aluop,
    output logic [31:0] mem_mem_addr,
    output logic [31:0] mem_reg2,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    localparam logic [7:0] C_EXE_NOP_OP = 8'h00;

    logic w_ex_stop;
    logic w_mem_stop;
    logic unused_stall_bits;

    assign w_ex_stop         = stall[3];
    assign w_mem_stop        = stall[4];
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

    // Bubble when EX stops but MEM runs; full hold when both stop.
    always_ff @(posedge clk) begin
        if (rst || flush || (w_ex_stop && !w_mem_stop)) begin
            mem_wd       <= 5'd0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= 32'd0;
            mem_whilo    <= 1'b0;
            mem_hi       <= 32'd0;
            mem_lo       <= 32'd0;
            mem_aluop    <= C_EXE_NOP_OP;
            mem_mem_addr <= 32'd0;
            mem_reg2     <= 32'd0;
        end else if (!w_ex_stop) begin
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
        end
    end

`ifdef EX_MEM_MADD_EN
    // The partial product survives only while EX is stalled on the madd.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hilo_o <= 64'd0;
            cnt_o  <= 2'd0;
        end else if (w_ex_stop) begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end else begin
            hilo_o <= 64'd0;
            cnt_o  <= 2'd0;
        end
    end
`else
    logic unused_madd_inputs;

    assign unused_madd_inputs = ^{hilo_i, cnt_i};
    assign hilo_o             = 64'd0;
    assign cnt_o              = 2'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem.sv
// ============================================================================
// Module   : tb_ex_mem
// Brief    : Directed self-checking bench for ex_mem (EX_MEM_MADD_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem;

`ifdef EX_MEM_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_mem dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_whilo     (ex_whilo),
        .ex_hi        (ex_hi),
        .ex_lo        (ex_lo),
        .ex_aluop     (ex_aluop),
        .ex_mem_addr  (ex_mem_addr),
        .ex_reg2      (ex_reg2),
        .hilo_i       (hilo_i),
        .cnt_i        (cnt_i),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .hilo_o       (hilo_o),
        .cnt_o        (cnt_o)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ex;
        ex_wd       = 5'($urandom);
        ex_wreg     = 1'b1;
        ex_wdata    = $urandom;
        ex_whilo    = 1'b1;
        ex_hi       = $urandom;
        ex_lo       = $urandom;
        ex_aluop    = 8'($urandom_range(1, 255));
        ex_mem_addr = $urandom;
        ex_reg2     = $urandom;
        hilo_i      = {$urandom, $urandom};
        cnt_i       = 2'($urandom_range(1, 3));
    endtask

    task automatic check_mem_zero(input string tag);
        check({tag, " mem"}, {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
                              mem_aluop, mem_mem_addr, mem_reg2}, '0);
    endtask

    task automatic check_madd(input string tag, input logic [63:0] h, input logic [1:0] c);
        check({tag, " hilo_o"}, hilo_o, MADD ? h : 64'd0);
        check({tag, " cnt_o"},  cnt_o,  MADD ? c : 2'd0);
    endtask

    logic [63:0] h_exp;
    logic [4:0]  wd_exp;

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        stall = 6'b001111;
        rand_ex();

        // Reset dominates even an active bubble stall with live madd inputs.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_mem_zero("reset");
            check_madd("reset", 64'd0, 2'd0);
            rand_ex();
        end

        rst      = 1'b0;
        stall    = 6'b000000;
        ex_wd    = 5'h03;
        ex_wreg  = 1'b1;
        ex_wdata = 32'h0000_FFFF;
        tick();
        check("post-reset wd", mem_wd, 5'h03);
        check("post-reset wreg", mem_wreg, 1'b1);
        check("post-reset wdata", mem_wdata, 32'h0000_FFFF);

        // Passthrough
        ex_hi       = 32'h1234_5678;
        ex_lo       = 32'h9ABC_DEF0;
        ex_whilo    = 1'b1;
        ex_mem_addr = 32'h0000_0100;
        ex_aluop    = 8'h24;
        ex_reg2     = 32'h5555_AAAA;
        hilo_i      = 64'hFFFF_0000_FFFF_0000;
        cnt_i       = 2'd1;
        tick();
        check("pass hi", mem_hi, 32'h1234_5678);
        check("pass lo", mem_lo, 32'h9ABC_DEF0);
        check("pass whilo", mem_whilo, 1'b1);
        check("pass addr", mem_mem_addr, 32'h0000_0100);
        check("pass aluop", mem_aluop, 8'h24);
        check("pass reg2", mem_reg2, 32'h5555_AAAA);
        check("pass hilo_o", hilo_o, 64'd0);
        check("pass cnt_o", cnt_o, 2'd0);

        // Bubble
        stall    = 6'b001111;
        ex_wreg  = 1'b1;
        ex_wdata = 32'h1111_2222;
        hilo_i   = 64'h0000_0001_0000_0002;
        cnt_i    = 2'd1;
        tick();
        check("bubble wreg", mem_wreg, 1'b0);
        check("bubble wdata", mem_wdata, 32'd0);
        check_mem_zero("bubble");
        check_madd("bubble", 64'h0000_0001_0000_0002, 2'd1);

        // Hold
        stall    = 6'b000000;
        ex_wd    = 5'h07;
        ex_wreg  = 1'b1;
        ex_wdata = 32'hDEAD_BEEF;
        tick();
        check("hold load", mem_wdata, 32'hDEAD_BEEF);
        wd_exp = 5'h07;
        stall  = 6'b011111;
        for (int i = 0; i < 4; i++) begin
            rand_ex();
            h_exp = hilo_i;
            tick();
            check("hold wdata", mem_wdata, 32'hDEAD_BEEF);
            check("hold wd", mem_wd, wd_exp);
            check_madd("hold", h_exp, cnt_i);
        end
        stall    = 6'b000000;
        ex_wdata = 32'hCAFE_0001;
        tick();
        check("release wdata", mem_wdata, 32'hCAFE_0001);
        check("release cnt_o", cnt_o, 2'd0);

        // Flush during madd
        stall  = 6'b001111;
        hilo_i = 64'hABCD_0000_0000_1234;
        cnt_i  = 2'd1;
        tick();
        check_madd("madd latch", 64'hABCD_0000_0000_1234, 2'd1);
        flush = 1'b1;
        rand_ex();
        tick();
        check_mem_zero("flush+stall");
        check_madd("flush+stall", 64'd0, 2'd0);
        stall = 6'b011111;
        rand_ex();
        tick();
        check_mem_zero("flush+hold");
        stall = 6'b000000;
        rand_ex();
        tick();
        check_mem_zero("flush+pass");
        flush = 1'b0;

        // Reset mid-madd
        stall  = 6'b001111;
        cnt_i  = 2'd1;
        hilo_i = 64'h1;
        tick();
        check_madd("madd latch2", 64'h1, 2'd1);
        rst = 1'b1;
        tick();
        check_madd("reset mid-madd", 64'd0, 2'd0);
        rst = 1'b0;

        // Illegal stall combination behaves as EX advancing
        stall    = 6'b010000;
        ex_wdata = 32'h0BAD_F00D;
        ex_aluop = 8'h23;
        tick();
        check("illegal wdata", mem_wdata, 32'h0BAD_F00D);
        check("illegal aluop", mem_aluop, 8'h23);
        check("illegal cnt_o", cnt_o, 2'd0);

        // All-ones product under bubble: latched only when the feature is built
        stall  = 6'b001111;
        hilo_i = '1;
        cnt_i  = 2'd2;
        tick();
        check_madd("ones", 64'hFFFF_FFFF_FFFF_FFFF, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
